// File: rtl/lru_victim_select.sv
// Per-way saturating age tracker with a one-way-per-cycle oldest-victim search.
// Optional build macro LRU_INVALID_FIRST_EN: the scan stops at the first invalid way.
module lru_victim_select #(
  parameter int WAYS      = 8,
  parameter int AGE_WIDTH = 4,
  parameter int IDX_W     = $clog2(WAYS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 hit_v_i,
  input  logic [IDX_W-1:0]     hit_way_i,
  input  logic                 fill_v_i,
  input  logic [IDX_W-1:0]     fill_way_i,
  input  logic                 inv_v_i,
  input  logic [IDX_W-1:0]     inv_way_i,
  input  logic                 victim_v_i,
  output logic                 victim_ready_o,
  output logic                 victim_v_o,
  output logic [IDX_W-1:0]     victim_way_o,
  output logic [AGE_WIDTH-1:0] victim_age_o,
  input  logic                 victim_yumi_i
);

  localparam logic [AGE_WIDTH-1:0] AMAX = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state;
  logic [AGE_WIDTH-1:0] age_q    [WAYS];
  logic [AGE_WIDTH-1:0] snap_age [WAYS];
  logic [WAYS-1:0]      valid_q;
  logic [WAYS-1:0]      snap_valid;
  logic [IDX_W-1:0]     idx;
  logic [AGE_WIDTH-1:0] best_age;
  logic [IDX_W-1:0]     best_way;
  logic [WAYS-1:0]      access;
  logic                 any_access;
  logic                 take_invalid;
  logic                 last_way;

  // A hit and a fill on the same way collapse into a single access.
  always_comb begin
    access = '0;
    for (int w = 0; w < WAYS; w++) begin
      access[w] = (hit_v_i && hit_way_i == IDX_W'(w)) ||
                  (fill_v_i && fill_way_i == IDX_W'(w));
    end
  end

  assign any_access = hit_v_i | fill_v_i;
  assign last_way   = (idx == IDX_W'(WAYS - 1));

`ifdef LRU_INVALID_FIRST_EN
  assign take_invalid = ~snap_valid[idx];
`else
  logic unused_snap_valid;
  assign unused_snap_valid = ^snap_valid;
  assign take_invalid      = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int w = 0; w < WAYS; w++) age_q[w] <= '0;
      valid_q <= '0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (any_access) begin
          if (access[w])
            age_q[w] <= '0;
          else if (age_q[w] != AMAX)
            age_q[w] <= age_q[w] + AGE_WIDTH'(1);
        end
        // Fill takes priority over a same-cycle invalidate of the same way.
        if (fill_v_i && fill_way_i == IDX_W'(w))
          valid_q[w] <= 1'b1;
        else if (inv_v_i && inv_way_i == IDX_W'(w))
          valid_q[w] <= 1'b0;
      end
    end
  end

  // The scan works only on the snapshot, so accesses in flight cannot disturb the result.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      victim_ready_o <= 1'b1;
      victim_v_o     <= 1'b0;
      idx            <= '0;
      best_age       <= '0;
      best_way       <= '0;
      snap_valid     <= '0;
      for (int w = 0; w < WAYS; w++) snap_age[w] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (victim_v_i) begin
            state          <= SCAN;
            victim_ready_o <= 1'b0;
            snap_age       <= age_q;
            snap_valid     <= valid_q;
            idx            <= '0;
            best_age       <= '0;
            best_way       <= '0;
          end
        end
        SCAN: begin
          if (take_invalid) begin
            best_age   <= snap_age[idx];
            best_way   <= idx;
            state      <= DONE;
            victim_v_o <= 1'b1;
          end else begin
            if (snap_age[idx] >= best_age) begin
              best_age <= snap_age[idx];
              best_way <= idx;
            end
            if (last_way) begin
              state      <= DONE;
              victim_v_o <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (victim_yumi_i) begin
            state          <= IDLE;
            victim_v_o     <= 1'b0;
            victim_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign victim_way_o = best_way;
  assign victim_age_o = best_age;

endmodule
